// File: rtl/load_store_sequencer_if.sv
// Request, memory-stage and writeback signals of the load/store sequencer.
// The master modport is the execute/memory side; the slave modport is the sequencer.
interface load_store_sequencer_if;
    logic        req_valid;
    logic        req_load;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_by;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        err;

    modport master (
        output req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write, mem_by,
        input  busy, ld_valid, ld_data, err
    );

    modport slave (
        input  req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write, mem_by,
        output busy, ld_valid, ld_data, err
    );
endinterface

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: issues aligned accesses in one cycle, splits misaligned
// half/word accesses into byte accesses under stall, and extends load data.
module load_store_sequencer #(
    parameter int MEM_DEPTH = 2048,
    parameter bit SPLIT_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_sequencer_if.slave bus
);

    typedef enum logic {IDLE, SPLIT} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sg);
        case (sz)
            SZ_BYTE: return {{24{sg & d[7]}}, d[7:0]};
            SZ_HALF: return {{16{sg & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    state_t      state, state_next;
    logic [1:0]  cnt;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [1:0]  l_size;
    logic        l_signed;
    logic        l_load;
    logic [31:0] asm_data;

    logic [2:0]  req_bytes;
    logic [32:0] req_last;
    logic        out_of_range;
    logic        misaligned;
    logic        reject;

    logic        err_set;
    logic        ld_set;
    logic [31:0] ld_value;
    logic        start_split;
    logic        split_last;
    logic [31:0] assembled;

    always_comb begin
        req_bytes = 3'd0;
        case (bus.req_size)
            SZ_BYTE: req_bytes = 3'd1;
            SZ_HALF: req_bytes = 3'd2;
            SZ_WORD: req_bytes = 3'd4;
            default: req_bytes = 3'd0;
        endcase
        // 33-bit end address so an access near 0xFFFFFFFF cannot wrap into range.
        req_last     = {1'b0, bus.req_addr} + {30'b0, req_bytes} - 33'd1;
        out_of_range = req_last >= 33'(MEM_DEPTH);
        misaligned   = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                       ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
        reject       = (bus.req_load == bus.req_store) || (bus.req_size == 2'b00) ||
                       out_of_range || (misaligned && !SPLIT_EN);
    end

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        state_next    = state;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_by    = 2'b00;
        bus.busy      = 1'b0;
        err_set       = 1'b0;
        ld_set        = 1'b0;
        ld_value      = 32'h0;
        start_split   = 1'b0;

        split_last = (cnt == ((l_size == SZ_WORD) ? 2'd3 : 2'd1));
        assembled  = asm_data;
        assembled[{cnt, 3'b000} +: 8] = bus.mem_rdata[7:0];
        if (l_size == SZ_HALF) assembled[31:16] = 16'h0;

        // Outputs are forced quiet while reset is held, even with a request pending.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (reject) begin
                            err_set = 1'b1;
                        end else if (!misaligned) begin
                            bus.mem_addr  = bus.req_addr;
                            bus.mem_wdata = bus.req_wdata;
                            bus.mem_read  = bus.req_load;
                            bus.mem_write = bus.req_store;
                            bus.mem_by    = bus.req_size;
                            ld_set        = bus.req_load;
                            ld_value      = extend(bus.mem_rdata, bus.req_size, bus.req_signed);
                        end else begin
                            bus.mem_addr  = bus.req_addr;
                            bus.mem_wdata = {24'h0, bus.req_wdata[7:0]};
                            bus.mem_read  = bus.req_load;
                            bus.mem_write = bus.req_store;
                            bus.mem_by    = SZ_BYTE;
                            bus.busy      = 1'b1;
                            start_split   = 1'b1;
                            state_next    = SPLIT;
                        end
                    end
                end
                SPLIT: begin
                    bus.mem_addr  = l_addr + {30'b0, cnt};
                    bus.mem_wdata = {24'h0, l_wdata[{cnt, 3'b000} +: 8]};
                    bus.mem_read  = l_load;
                    bus.mem_write = !l_load;
                    bus.mem_by    = SZ_BYTE;
                    bus.busy      = !split_last;
                    if (split_last) begin
                        state_next = IDLE;
                        ld_set     = l_load;
                        ld_value   = extend(assembled, l_size, l_signed);
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 2'd0;
            l_addr       <= 32'h0;
            l_wdata      <= 32'h0;
            l_size       <= 2'b00;
            l_signed     <= 1'b0;
            l_load       <= 1'b0;
            asm_data     <= 32'h0;
            bus.ld_data  <= 32'h0;
            bus.ld_valid <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.ld_valid <= ld_set;
            bus.err      <= err_set;
            if (ld_set) bus.ld_data <= ld_value;
            if (start_split) begin
                l_addr   <= bus.req_addr;
                l_wdata  <= bus.req_wdata;
                l_size   <= bus.req_size;
                l_signed <= bus.req_signed;
                l_load   <= bus.req_load;
                asm_data <= {24'h0, bus.mem_rdata[7:0]};
                cnt      <= 2'd1;
            end else if (state == SPLIT) begin
                if (split_last) begin
                    cnt <= 2'd0;
                end else begin
                    cnt <= cnt + 2'd1;
                    asm_data[{cnt, 3'b000} +: 8] <= bus.mem_rdata[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Scoreboard bench for load_store_sequencer: a byte memory model serves the DUT,
// expected writes, loads and errors are queued at issue and checked by a monitor.
module tb_load_store_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_sequencer_if bus();
    load_store_sequencer_if bus0();

    load_store_sequencer #(.MEM_DEPTH(2048), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    load_store_sequencer #(.MEM_DEPTH(2048), .SPLIT_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  by;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_ld[$];
    int          exp_err = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic [7:0] mem [0:2047];

    initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

    always_comb begin
        logic [10:0] a;
        a = bus.mem_addr[10:0];
        bus.mem_rdata = 32'h0;
        if (bus.mem_read) begin
            case (bus.mem_by)
                2'b01:   bus.mem_rdata = {24'h0, mem[a]};
                2'b10:   bus.mem_rdata = {16'h0, mem[a + 11'd1], mem[a]};
                2'b11:   bus.mem_rdata = {mem[a + 11'd3], mem[a + 11'd2], mem[a + 11'd1], mem[a]};
                default: bus.mem_rdata = 32'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr[10:0]] <= bus.mem_wdata[7:0];
            if (bus.mem_by[1]) mem[bus.mem_addr[10:0] + 11'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_by == 2'b11) begin
                mem[bus.mem_addr[10:0] + 11'd2] <= bus.mem_wdata[23:16];
                mem[bus.mem_addr[10:0] + 11'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    assign bus0.mem_rdata = 32'h0000A5C3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: consumes queued expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_read && bus.mem_write) begin
                n_checks++;
                $display("FAIL strobe_exclusive: read and write both high at 0x%08h", bus.mem_addr);
            end
            if ((bus.mem_read || bus.mem_write) && bus.mem_by == 2'b00) begin
                n_checks++;
                $display("FAIL strobe_size: mem_by 00 with a strobe at 0x%08h", bus.mem_addr);
            end
            if (bus.mem_write) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h", bus.mem_addr, bus.mem_wdata);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", bus.mem_addr, w.addr);
                    check("wr_data", bus.mem_wdata, w.data);
                    check("wr_by", {30'h0, bus.mem_by}, {30'h0, w.by});
                end
            end
            if (bus.ld_valid) begin
                if (exp_ld.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_load: ld_data 0x%08h", bus.ld_data);
                end else begin
                    check("ld_data", bus.ld_data, exp_ld.pop_front());
                end
            end
            if (bus.err) begin
                n_checks++;
                if (exp_err > 0) begin
                    n_pass++;
                    exp_err--;
                end else begin
                    $display("FAIL unexpected_err: err pulse with none expected");
                end
            end
        end
    end

    // Issue one request, hold it while busy, then check latency and the response pulses.
    task automatic do_req(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input int exp_cyc, input logic rej);
        int   cyc;
        logic b;
        logic strobe;
        cyc    = 0;
        strobe = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_store  = st;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        do begin
            @(negedge clk);
            cyc++;
            b = bus.busy;
            strobe = strobe | bus.mem_read | bus.mem_write;
            @(posedge clk);
            #1;
        end while (b && cyc < 20);
        bus.req_valid = 1'b0;
        check({nm, "_cycles"}, cyc, exp_cyc);
        check({nm, "_strobe"}, {31'h0, strobe}, {31'h0, !rej});
        check({nm, "_ld_valid"}, {31'h0, bus.ld_valid}, {31'h0, ld && !rej});
        check({nm, "_err"}, {31'h0, bus.err}, {31'h0, rej});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus0.req_valid = 1'b0; bus0.req_load = 1'b0; bus0.req_store = 1'b0; bus0.req_size = 2'b00;
        bus0.req_signed = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        check("rst_ld_data", bus.ld_data, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        check("idle_addr", bus.mem_addr, 32'h0);
        check("idle_by", {30'h0, bus.mem_by}, 32'h0);

        // Aligned word store and load
        exp_wr.push_back('{32'h10, 32'hDEADBEEF, 2'b11});
        do_req("sw_aligned", 1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0);
        exp_ld.push_back(32'hDEADBEEF);
        do_req("lw_aligned", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 1'b0);

        // Byte loads, signed and unsigned
        exp_ld.push_back(32'hFFFFFFEF);
        do_req("lb", 1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1, 1'b0);
        exp_ld.push_back(32'h000000EF);
        do_req("lbu", 1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1, 1'b0);

        // Misaligned word store split into four bytes, then misaligned word load
        exp_wr.push_back('{32'h13, 32'h44, 2'b01});
        exp_wr.push_back('{32'h14, 32'h33, 2'b01});
        exp_wr.push_back('{32'h15, 32'h22, 2'b01});
        exp_wr.push_back('{32'h16, 32'h11, 2'b01});
        do_req("sw_split", 1'b0, 1'b1, 2'b11, 1'b0, 32'h13, 32'h11223344, 4, 1'b0);
        exp_ld.push_back(32'h11223344);
        do_req("lw_split", 1'b1, 1'b0, 2'b11, 1'b0, 32'h13, 32'h0, 4, 1'b0);

        // Word load ignores req_signed: bytes EF BE AD 44 at 0x10..0x13
        exp_ld.push_back(32'h44ADBEEF);
        do_req("lw_signed", 1'b1, 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1, 1'b0);

        // Half loads
        exp_wr.push_back('{32'h15, 32'h80, 2'b01});
        do_req("sb_15", 1'b0, 1'b1, 2'b01, 1'b0, 32'h15, 32'h80, 1, 1'b0);
        exp_wr.push_back('{32'h16, 32'h7F, 2'b01});
        do_req("sb_16", 1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'h7F, 1, 1'b0);
        exp_ld.push_back(32'h00007F80);
        do_req("lh_split", 1'b1, 1'b0, 2'b10, 1'b1, 32'h15, 32'h0, 2, 1'b0);
        exp_ld.push_back(32'hFFFF8033);
        do_req("lh_aligned", 1'b1, 1'b0, 2'b10, 1'b1, 32'h14, 32'h0, 1, 1'b0);
        exp_ld.push_back(32'h00008033);
        do_req("lhu_aligned", 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1, 1'b0);

        // Top-of-memory boundary, legal side
        exp_wr.push_back('{32'h7FF, 32'h9A, 2'b01});
        do_req("sb_top", 1'b0, 1'b1, 2'b01, 1'b0, 32'h7FF, 32'h9A, 1, 1'b0);
        exp_ld.push_back(32'hFFFFFF9A);
        do_req("lb_top", 1'b1, 1'b0, 2'b01, 1'b1, 32'h7FF, 32'h0, 1, 1'b0);
        exp_ld.push_back(32'h9A000000);
        do_req("lw_top", 1'b1, 1'b0, 2'b11, 1'b0, 32'h7FC, 32'h0, 1, 1'b0);

        // Rejections
        exp_err++;
        do_req("rej_lw_range", 1'b1, 1'b0, 2'b11, 1'b0, 32'h7FE, 32'h0, 1, 1'b1);
        exp_err++;
        do_req("rej_lh_range", 1'b1, 1'b0, 2'b10, 1'b0, 32'h7FF, 32'h0, 1, 1'b1);
        exp_err++;
        do_req("rej_lb_wrap", 1'b1, 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1, 1'b1);
        exp_err++;
        do_req("rej_size0", 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1, 1'b1);
        exp_err++;
        do_req("rej_both", 1'b1, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0, 1, 1'b1);
        exp_err++;
        do_req("rej_neither", 1'b0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1, 1'b1);

        // SPLIT_EN=0 instance: misaligned rejected, aligned accepted
        bus0.req_valid = 1'b1; bus0.req_load = 1'b1; bus0.req_store = 1'b0;
        bus0.req_size = 2'b10; bus0.req_signed = 1'b1; bus0.req_addr = 32'h1;
        @(negedge clk);
        check("nosplit_rej_busy", {31'h0, bus0.busy}, 32'h0);
        check("nosplit_rej_strobe", {30'h0, bus0.mem_read, bus0.mem_write}, 32'h0);
        @(posedge clk);
        #1;
        check("nosplit_rej_err", {31'h0, bus0.err}, 32'h1);
        check("nosplit_rej_ld_valid", {31'h0, bus0.ld_valid}, 32'h0);
        bus0.req_addr = 32'h2;
        @(negedge clk);
        check("nosplit_lh_read", {31'h0, bus0.mem_read}, 32'h1);
        check("nosplit_lh_by", {30'h0, bus0.mem_by}, 32'h2);
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        check("nosplit_lh_ld_valid", {31'h0, bus0.ld_valid}, 32'h1);
        check("nosplit_lh_ld_data", bus0.ld_data, 32'hFFFFA5C3);
        check("nosplit_lh_err", {31'h0, bus0.err}, 32'h0);

        // Reset in the middle of a split store
        exp_wr.push_back('{32'h21, 32'hDD, 2'b01});
        bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_store = 1'b1; bus.req_size = 2'b11;
        bus.req_signed = 1'b0; bus.req_addr = 32'h21; bus.req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        check("split_rst_busy0", {31'h0, bus.busy}, 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("split_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("split_rst_write", {31'h0, bus.mem_write}, 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        check("split_rst_byte0", {24'h0, mem[11'h21]}, 32'hDD);
        check("split_rst_byte1", {24'h0, mem[11'h22]}, 32'h00);
        exp_ld.push_back(32'h0000DD00);
        do_req("lw_after_rst", 1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("wr_queue_drained", 32'(exp_wr.size()), 32'h0);
        check("ld_queue_drained", 32'(exp_ld.size()), 32'h0);
        check("err_queue_drained", 32'(exp_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
